// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus and handshake signals of the SM83 instruction fetch stage.
//   mem_addr/mem_rd/mem_data : synchronous memory read port (data returns one cycle after mem_rd)
//   bus_stall                : control owns the shared bus this cycle
//   redirect/redirect_pc     : control-flow redirect from control
//   instr_*                  : decoded-length instruction offered to control (valid/ready)
// master = fetch unit side, slave = memory/control side.
interface fetch_unit_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        bus_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [7:0]  instr_opcode;
    logic        instr_cb;
    logic [15:0] instr_imm;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] next_pc;

    modport master (
        output mem_addr, mem_rd,
        input  mem_data, bus_stall, redirect, redirect_pc, instr_ready,
        output instr_valid, instr_opcode, instr_cb, instr_imm, instr_len, instr_pc, next_pc
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_data, bus_stall, redirect, redirect_pc, instr_ready,
        input  instr_valid, instr_opcode, instr_cb, instr_imm, instr_len, instr_pc, next_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: SM83 instruction fetch stage.
// Reads opcode and operand bytes one at a time from synchronous memory, works out the
// instruction length (CB prefix included) and holds the complete instruction on instr_*
// until control accepts it. A redirect restarts fetching at redirect_pc.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master: memory read port, stall, redirect and instruction handshake
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam logic [2:0] StFetchOp = 3'd0;
    localparam logic [2:0] StCapOp   = 3'd1;
    localparam logic [2:0] StFetchB1 = 3'd2;
    localparam logic [2:0] StCapB1   = 3'd3;
    localparam logic [2:0] StFetchB2 = 3'd4;
    localparam logic [2:0] StCapB2   = 3'd5;
    localparam logic [2:0] StHold    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        cb_q, cb_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] next_pc_q, next_pc_d;

    logic        is_fetch;
    logic        rd;
    logic [1:0]  op_len;

    // Total length of an unprefixed opcode; everything not listed (illegal ones too) is 1 byte.
    function automatic logic [1:0] len_of(input logic [7:0] op);
        logic [1:0] l;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:                                   l = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:              l = 2'd3;
            default:                                                      l = 2'd1;
        endcase
        return l;
    endfunction

    assign is_fetch = (state_q == StFetchOp) || (state_q == StFetchB1) || (state_q == StFetchB2);
    // No read in the redirect cycle: the address would belong to the flushed stream.
    assign rd       = !rst && !bus.redirect && !bus.bus_stall && is_fetch;
    assign op_len   = (bus.mem_data == 8'hCB) ? 2'd2 : len_of(bus.mem_data);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        opcode_d   = opcode_q;
        cb_d       = cb_q;
        imm_d      = imm_q;
        len_d      = len_q;
        pc_d       = pc_q;
        next_pc_d  = next_pc_q;

        if (bus.redirect) begin
            // Also covers redirect+ready in HOLD: the held instruction is simply dropped.
            state_d    = StFetchOp;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            case (state_q)
                StFetchOp: if (!bus.bus_stall) state_d = StCapOp;
                StFetchB1: if (!bus.bus_stall) state_d = StCapB1;
                StFetchB2: if (!bus.bus_stall) state_d = StCapB2;
                StCapOp: begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    pc_d       = fetch_pc_q;
                    opcode_d   = bus.mem_data;
                    cb_d       = (bus.mem_data == 8'hCB);
                    imm_d      = 16'h0000;
                    len_d      = op_len;
                    next_pc_d  = fetch_pc_q + {14'd0, op_len};
                    state_d    = (op_len == 2'd1) ? StHold : StFetchB1;
                end
                StCapB1: begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    // After a CB prefix the second byte is the real opcode.
                    if (cb_q) opcode_d   = bus.mem_data;
                    else      imm_d[7:0] = bus.mem_data;
                    state_d = (len_q == 2'd3) ? StFetchB2 : StHold;
                end
                StCapB2: begin
                    fetch_pc_d  = fetch_pc_q + 16'd1;
                    imm_d[15:8] = bus.mem_data;
                    state_d     = StHold;
                end
                StHold:  if (bus.instr_ready) state_d = StFetchOp;
                default: state_d = StFetchOp;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetchOp;
            fetch_pc_q <= RESET_PC;
            opcode_q   <= 8'h00;
            cb_q       <= 1'b0;
            imm_q      <= 16'h0000;
            len_q      <= 2'd0;
            pc_q       <= 16'h0000;
            next_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            opcode_q   <= opcode_d;
            cb_q       <= cb_d;
            imm_q      <= imm_d;
            len_q      <= len_d;
            pc_q       <= pc_d;
            next_pc_q  <= next_pc_d;
        end
    end

    assign bus.mem_rd       = rd;
    assign bus.mem_addr     = rd ? fetch_pc_q : 16'h0000;
    assign bus.instr_valid  = (state_q == StHold);
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_cb     = cb_q;
    assign bus.instr_imm    = imm_q;
    assign bus.instr_len    = len_q;
    assign bus.instr_pc     = pc_q;
    assign bus.next_pc      = next_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized ROM/stall/ready/redirect traffic,
// every presented instruction checked against a byte-level model of the ROM contents.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] rom [0:65535];

    // Synchronous memory: data one cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= rom[bus.mem_addr];
        else            bus.mem_data <= 8'($urandom);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] two_b   [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                                 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                                 8'hE8, 8'hF8};
    logic [7:0] three_b [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                                 8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA,
                                 8'hFA};

    function automatic int ref_len(input logic [7:0] op);
        int l;
        l = 1;
        if (op == 8'hCB) l = 2;
        foreach (two_b[i])   if (two_b[i] == op)   l = 2;
        foreach (three_b[i]) if (three_b[i] == op) l = 3;
        return l;
    endfunction

    typedef struct {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic [15:0] npc;
    } instr_t;

    // What control should see for an instruction starting at pc.
    function automatic instr_t ref_instr(input logic [15:0] pc);
        instr_t e;
        logic [15:0] p1;
        logic [15:0] p2;
        int l;
        p1 = pc + 16'd1;
        p2 = pc + 16'd2;
        l  = ref_len(rom[pc]);
        e.pc  = pc;
        e.len = 2'(l);
        e.npc = pc + 16'(l);
        e.cb  = (rom[pc] == 8'hCB);
        e.op  = e.cb ? rom[p1] : rom[pc];
        e.imm = 16'h0000;
        if (!e.cb && l >= 2) e.imm[7:0]  = rom[p1];
        if (l == 3)          e.imm[15:8] = rom[p2];
        return e;
    endfunction

    task automatic check_instr(input instr_t e);
        chk("instr_valid",  bus.instr_valid,  1'b1);
        chk("instr_opcode", bus.instr_opcode, e.op);
        chk("instr_cb",     bus.instr_cb,     e.cb);
        chk("instr_imm",    bus.instr_imm,    e.imm);
        chk("instr_len",    bus.instr_len,    e.len);
        chk("instr_pc",     bus.instr_pc,     e.pc);
        chk("next_pc",      bus.next_pc,      e.npc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until instr_valid, bounded by max.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.instr_valid && n < max);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        #1;
        chk("rd_in_redirect", bus.mem_rd, 1'b0);
        tick();
        bus.redirect = 1'b0;
        #1;
    endtask

    int n;
    logic [15:0] model_pc;
    logic [15:0] diff;
    instr_t cur;
    bit seen;
    int idle;

    initial begin
        rst             = 1'b1;
        bus.bus_stall   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;

        // Reset state and a 1-byte NOP at the reset vector.
        tick();
        tick();
        chk("rst_valid",   bus.instr_valid,  1'b0);
        chk("rst_opcode",  bus.instr_opcode, 8'h00);
        chk("rst_cb",      bus.instr_cb,     1'b0);
        chk("rst_imm",     bus.instr_imm,    16'h0000);
        chk("rst_len",     bus.instr_len,    2'd0);
        chk("rst_pc",      bus.instr_pc,     16'h0000);
        chk("rst_next_pc", bus.next_pc,      16'h0000);
        chk("rst_mem_rd",  bus.mem_rd,       1'b0);
        rst = 1'b0;
        #1;
        chk("first_rd",   bus.mem_rd,   1'b1);
        chk("first_addr", bus.mem_addr, 16'h0000);
        wait_valid(20, n);
        chk("lat_1byte", 32'(n), 32'd2);
        check_instr(ref_instr(16'h0000));

        // 3-byte LD BC,d16 at 0000 with ready held high.
        rst = 1'b1;
        rom[0] = 8'h01; rom[1] = 8'h34; rom[2] = 8'h12;
        tick();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        wait_valid(20, n);
        chk("lat_3byte", 32'(n), 32'd6);
        chk("ld_imm", bus.instr_imm, 16'h1234);
        check_instr(ref_instr(16'h0000));
        tick();
        chk("after_consume_valid", bus.instr_valid, 1'b0);
        chk("after_consume_rd",    bus.mem_rd,      1'b1);
        chk("after_consume_addr",  bus.mem_addr,    16'h0003);

        // CB-prefixed instruction reached through a redirect.
        rom[16'h0010] = 8'hCB; rom[16'h0011] = 8'h7C;
        redirect_to(16'h0010);
        wait_valid(20, n);
        chk("lat_cb", 32'(n), 32'd4);
        chk("cb_flag", bus.instr_cb, 1'b1);
        check_instr(ref_instr(16'h0010));
        tick();

        // Three stall cycles while waiting to fetch byte1 of LD A,d8.
        rom[16'h0020] = 8'h3E; rom[16'h0021] = 8'h55;
        redirect_to(16'h0020);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.bus_stall = 1'b1;
            #1;
            chk("stall_rd",   bus.mem_rd,   1'b0);
            chk("stall_addr", bus.mem_addr, 16'h0000);
            tick();
        end
        bus.bus_stall = 1'b0;
        #1;
        chk("unstall_addr", bus.mem_addr, 16'h0021);
        wait_valid(20, n);
        chk("lat_after_stall", 32'(n), 32'd2);
        check_instr(ref_instr(16'h0020));
        tick();

        // Redirect while capturing byte1 of a 3-byte instruction: it must never show up.
        rom[16'h0030] = 8'h01; rom[16'h0031] = 8'hAA; rom[16'h0032] = 8'hBB;
        rom[16'h0100] = 8'hAF;
        redirect_to(16'h0030);
        tick();
        tick();
        tick();
        redirect_to(16'h0100);
        chk("redir_valid", bus.instr_valid, 1'b0);
        chk("redir_rd",    bus.mem_rd,      1'b1);
        chk("redir_addr",  bus.mem_addr,    16'h0100);
        wait_valid(20, n);
        chk("lat_redir", 32'(n), 32'd2);
        check_instr(ref_instr(16'h0100));
        tick();

        // JR at FFFF: operand fetch wraps to 0000.
        rom[16'hFFFF] = 8'h18; rom[16'h0000] = 8'hFE;
        redirect_to(16'hFFFF);
        wait_valid(20, n);
        chk("lat_wrap", 32'(n), 32'd4);
        check_instr(ref_instr(16'hFFFF));
        tick();
        chk("wrap_next_addr", bus.mem_addr, 16'h0001);

        // Randomized traffic over a random ROM.
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        model_pc = 16'($urandom);
        redirect_to(model_pc);
        seen = 1'b0;
        idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bus.instr_valid && !seen) begin
                cur = ref_instr(model_pc);
                check_instr(cur);
                seen = 1'b1;
            end
            bus.bus_stall   = ($urandom_range(0, 3) == 0);
            bus.instr_ready = ($urandom_range(0, 1) == 1);
            bus.redirect    = ($urandom_range(0, 39) == 0);
            bus.redirect_pc = 16'($urandom);
            #1;
            if (bus.bus_stall || bus.redirect) chk("rd_blocked", bus.mem_rd, 1'b0);
            if (!bus.mem_rd) begin
                chk("addr_idle", bus.mem_addr, 16'h0000);
            end else begin
                diff = bus.mem_addr - model_pc;
                chk("rd_window", (diff < 16'd3), 1'b1);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                model_pc = cur.npc;
                seen     = 1'b0;
                idle     = 0;
            end
            if (bus.redirect) begin
                model_pc = bus.redirect_pc;
                seen     = 1'b0;
                idle     = 0;
            end
            idle++;
            if (idle > 200) begin
                chk("progress_watchdog", 32'(idle), 32'd200);
                break;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
